// File: rtl/kl_code_sequencer_if.sv
// Button, control and code signals between the digit-code sequencer and its environment.
interface kl_code_sequencer_if;
    logic       btn_step;
    logic       btn_mode;
    logic       up;
    logic       clr;
    logic [3:0] code;
    logic       auto_mode;
    logic       step;

    modport master (
        output btn_step, btn_mode, up, clr,
        input  code, auto_mode, step
    );

    modport slave (
        input  btn_step, btn_mode, up, clr,
        output code, auto_mode, step
    );
endinterface

// File: rtl/kl_code_sequencer.sv
// Generates the 0-9 digit code for the 7-segment decoder, advanced by a debounced
// step button (MANUAL) or by a prescaled tick (AUTO); a mode button toggles between them.
module kl_code_sequencer #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned DIV      = 8
) (
    input  logic                clk,
    input  logic                reset,
    kl_code_sequencer_if.slave  bus
);

    localparam int unsigned CNT_W    = $clog2(DEBOUNCE);
    localparam int unsigned PRE_W    = $clog2(DIV);
    localparam int unsigned CODE_W   = 4;
    localparam int unsigned NBTN     = 2;
    localparam int unsigned BTN_STEP = 0;
    localparam int unsigned BTN_MODE = 1;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

    logic [NBTN-1:0]   raw_c;
    logic [NBTN-1:0]   s1;
    logic [NBTN-1:0]   s2;
    logic [NBTN-1:0]   db;
    logic [NBTN-1:0]   db_q;
    logic [NBTN-1:0]   press_c;
    logic [CNT_W-1:0]  cnt [NBTN];

    state_t            state_q, state_d;
    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              step_q, step_d;
    logic              tick_c;
    logic              adv_c;

    assign raw_c   = {bus.btn_mode, bus.btn_step};
    assign press_c = db & ~db_q;

    // Synchronize and debounce both buttons; a level is accepted after DEBOUNCE stable cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= '0;
            s2   <= '0;
            db   <= '0;
            db_q <= '0;
            for (int i = 0; i < int'(NBTN); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1   <= raw_c;
            s2   <= s1;
            db_q <= db;
            for (int i = 0; i < int'(NBTN); i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(DEBOUNCE - 1)) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    function automatic logic [CODE_W-1:0] next_code(input logic [CODE_W-1:0] c, input logic up);
        if (c > CODE_W'(9)) begin
            return '0;
        end else if (up) begin
            return (c == CODE_W'(9)) ? '0 : c + CODE_W'(1);
        end else begin
            return (c == '0) ? CODE_W'(9) : c - CODE_W'(1);
        end
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MANUAL;
            presc_q <= '0;
            code_q  <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            code_q  <= code_d;
            step_q  <= step_d;
        end
    end

    // Next state: clear beats mode toggle, which beats any advance in the same cycle.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        code_d  = code_q;
        step_d  = 1'b0;
        tick_c  = 1'b0;
        adv_c   = 1'b0;

        if (state_q == AUTO) begin
            tick_c  = (presc_q == PRE_W'(DIV - 1));
            presc_d = tick_c ? '0 : presc_q + PRE_W'(1);
            adv_c   = tick_c;
        end else begin
            presc_d = '0;
            adv_c   = press_c[BTN_STEP];
        end

        if (bus.clr) begin
            code_d  = '0;
            presc_d = '0;
        end else if (press_c[BTN_MODE]) begin
            state_d = (state_q == MANUAL) ? AUTO : MANUAL;
            presc_d = '0;
        end else if (adv_c) begin
            code_d = next_code(code_q, bus.up);
            step_d = 1'b1;
        end
    end

    assign bus.code      = code_q;
    assign bus.auto_mode = (state_q == AUTO);
    assign bus.step      = step_q;

endmodule

// File: tb/tb_kl_code_sequencer.sv
// Directed bench for kl_code_sequencer: button latency, wrap, bounce, AUTO cadence,
// priority collisions and asynchronous reset.
module tb_kl_code_sequencer;

    localparam int unsigned DEBOUNCE = 4;
    localparam int unsigned DIV      = 8;

    logic clk = 1'b0;
    logic reset;

    kl_code_sequencer_if bus ();

    kl_code_sequencer #(
        .DEBOUNCE (DEBOUNCE),
        .DIV      (DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int chg_e[$];
    int chg_v[$];
    int steps;
    int auto_e;
    int auto_n;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive n edges with buttons/clr high inside the given edge windows; log code changes.
    task automatic run(input int n, input int s_on, input int s_off,
                       input int m_on, input int m_off, input int c_on, input int c_off);
        int pc;
        int pa;
        chg_e.delete();
        chg_v.delete();
        steps  = 0;
        auto_e = -1;
        auto_n = 0;
        pc = int'(bus.code);
        pa = int'(bus.auto_mode);
        for (int e = 1; e <= n; e++) begin
            bus.btn_step = (e >= s_on) && (e <= s_off);
            bus.btn_mode = (e >= m_on) && (e <= m_off);
            bus.clr      = (e >= c_on) && (e <= c_off);
            @(posedge clk);
            #1;
            if (int'(bus.code) != pc) begin
                chg_e.push_back(e);
                chg_v.push_back(int'(bus.code));
                pc = int'(bus.code);
            end
            if (bus.step) steps++;
            if (int'(bus.auto_mode) != pa) begin
                auto_n++;
                if (auto_e < 0) auto_e = e;
                pa = int'(bus.auto_mode);
            end
            @(negedge clk);
        end
        bus.btn_step = 1'b0;
        bus.btn_mode = 1'b0;
        bus.clr      = 1'b0;
    endtask

    task automatic expect_chg(input string tag, input int n,
                              input int e0, input int v0, input int e1, input int v1,
                              input int e2, input int v2, input int e3, input int v3);
        int ee[4];
        int vv[4];
        ee[0] = e0; ee[1] = e1; ee[2] = e2; ee[3] = e3;
        vv[0] = v0; vv[1] = v1; vv[2] = v2; vv[3] = v3;
        chk($sformatf("%s_nchg", tag), chg_e.size(), n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_edge%0d", tag, i), (i < chg_e.size()) ? chg_e[i] : -1, ee[i]);
            chk($sformatf("%s_code%0d", tag, i), (i < chg_v.size()) ? chg_v[i] : -1, vv[i]);
        end
    endtask

    initial begin
        bus.btn_step = 1'b0;
        bus.btn_mode = 1'b0;
        bus.up       = 1'b1;
        bus.clr      = 1'b0;
        reset        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_code", int'(bus.code), 0);
        chk("rst_auto", int'(bus.auto_mode), 0);
        chk("rst_step", int'(bus.step), 0);
        @(negedge clk);
        reset = 1'b0;

        // Eleven step presses count 1..9, wrap to 0, then 1; each lands on edge 7.
        for (int p = 0; p < 11; p++) begin
            run(20, 1, 10, 0, -1, 0, -1);
            expect_chg($sformatf("press%0d", p), 1, 7, (p + 1) % 10, 0, 0, 0, 0, 0, 0);
            chk($sformatf("press%0d_steps", p), steps, 1);
        end

        run(3, 0, -1, 0, -1, 1, 1);
        expect_chg("clr_manual", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("clr_manual_steps", steps, 0);
        chk("clr_manual_auto", int'(bus.auto_mode), 0);

        for (int p = 0; p < 5; p++) begin
            run(12, 1, 3, 0, -1, 0, -1);
            expect_chg($sformatf("bounce%0d", p), 0, 0, 0, 0, 0, 0, 0, 0, 0);
            chk($sformatf("bounce%0d_steps", p), steps, 0);
        end

        bus.up = 1'b0;
        run(20, 1, 10, 0, -1, 0, -1);
        expect_chg("dec0", 1, 7, 9, 0, 0, 0, 0, 0, 0);
        run(20, 1, 10, 0, -1, 0, -1);
        expect_chg("dec1", 1, 7, 8, 0, 0, 0, 0, 0, 0);
        chk("dec_steps", steps, 1);
        bus.up = 1'b1;

        // Enter AUTO at edge 7; ticks follow at 15, 23, 31.
        run(32, 0, -1, 1, 10, 0, -1);
        chk("auto_enter_edge", auto_e, 7);
        chk("auto_enter_n", auto_n, 1);
        expect_chg("auto", 3, 15, 9, 23, 0, 31, 1, 0, 0);
        chk("auto_steps", steps, 3);

        // Step press would land on edge 9; only the ticks at 7 and 15 may advance.
        run(16, 3, 12, 0, -1, 0, -1);
        expect_chg("auto_stepign", 2, 7, 2, 15, 3, 0, 0, 0, 0);
        chk("auto_stepign_steps", steps, 2);

        // Mode toggle lands exactly on a tick edge: state flips, code stays.
        run(30, 0, -1, 1, 10, 0, -1);
        chk("tog_tick_edge", auto_e, 7);
        chk("tog_tick_n", auto_n, 1);
        chk("tog_tick_auto", int'(bus.auto_mode), 0);
        expect_chg("tog_tick", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("tog_tick_steps", steps, 0);

        // Clear on the first tick edge restarts the cadence.
        run(24, 0, -1, 1, 10, 15, 15);
        chk("clr_tick_auto_edge", auto_e, 7);
        expect_chg("clr_tick", 2, 15, 0, 23, 1, 0, 0, 0, 0);
        chk("clr_tick_steps", steps, 1);
        chk("clr_tick_mode", int'(bus.auto_mode), 1);

        // Advance to code 5, then six more edges put the prescaler at 6.
        run(37, 0, -1, 0, -1, 0, -1);
        expect_chg("pre_rst", 4, 7, 2, 15, 3, 23, 4, 31, 5);

        #2 reset = 1'b1;
        #1;
        chk("async_code", int'(bus.code), 0);
        chk("async_auto", int'(bus.auto_mode), 0);
        chk("async_step", int'(bus.step), 0);
        #1 reset = 1'b0;

        run(30, 0, -1, 0, -1, 0, -1);
        expect_chg("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_auto_n", auto_n, 0);
        chk("post_rst_steps", steps, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
